// File: rtl/div32_seq.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per cycle,
// MSB first, with a single operation in flight at a time.
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: an operand pair transfers on a rising edge with in_valid && in_ready;
  // a result transfers on a rising edge with out_valid && out_ready. Both ready/valid
  // outputs are registered, so a result edge never also accepts a new operand pair.

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH+1:0] trial;
  logic             fits;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_dvd;

  always_comb begin
    // Shift the next dividend bit into the partial remainder and try a subtraction;
    // the dividend register doubles as the quotient accumulator.
    trial    = {rem_q, dvd_q[WIDTH-1]};
    fits     = (trial >= {2'b00, dsr_q});
    step_rem = fits ? WIDTH'(0) + (trial[WIDTH:0] - {1'b0, dsr_q}) : trial[WIDTH:0];
    step_dvd = {dvd_q[WIDTH-2:0], fits};

    state_d     = state_q;
    count_d     = count_q;
    dvd_d       = dvd_q;
    dsr_d       = dsr_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          dvd_d      = dividend;
          dsr_d      = divisor;
          rem_d      = '0;
          count_d    = '0;
          in_ready_d = 1'b0;
          if (divisor == '0) begin
            state_d     = S_DONE;
            quot_d      = '1;
            rmd_d       = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        rem_d   = step_rem;
        dvd_d   = step_dvd;
        count_d = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d     = S_DONE;
          quot_d      = step_dvd;
          rmd_d       = step_rem[WIDTH-1:0];
          dbz_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      dvd_q       <= dvd_d;
      dsr_q       <= dsr_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      rmd_q       <= rmd_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign quotient    = quot_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_div32_seq.sv
// Directed and random checks of div32_seq against plain-arithmetic division.
module tb_div32_seq;

  localparam int W        = 32;
  localparam int N_RANDOM = 1500;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  int checks = 0;
  int errors = 0;

  div32_seq #(.WIDTH(W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .dividend    (dividend),
    .divisor     (divisor),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state_dbg   (state_dbg)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction. Inputs change on the falling edge; outputs are sampled on
  // the falling edge that follows each rising edge.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, input bit noise);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edz;
    int           n;
    int           exp_lat;
    if (b == '0) begin
      eq = '1; er = a; edz = 1'b1; exp_lat = 0;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0; exp_lat = W;
    end
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = 1'b0;
    @(negedge CLK);
    in_valid = noise;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (out_valid !== 1'b1 && n < W + 10) begin
      chk("in_ready_busy", in_ready, 0);
      @(negedge CLK);
      n++;
      if (noise) begin
        dividend = $urandom;
        divisor  = $urandom;
      end
    end
    chk("latency", n, exp_lat);
    chk("in_ready_done", in_ready, 0);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    for (int s = 0; s < stall; s++) begin
      @(negedge CLK);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_dbz", div_by_zero, edz);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("consumed_valid", out_valid, 0);
    chk("consumed_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    RST       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    RST = 1'b1;
    @(negedge CLK);

    do_op(100, 7, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 1, 0, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_op(3, 10, 0, 1'b0);
    do_op(5, 0, 0, 1'b0);
    do_op(100, 7, 5, 1'b1);

    // Reset asserted for the 10th rising edge spent in RUN.
    in_valid = 1'b1;
    dividend = 100;
    divisor  = 7;
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (9) @(negedge CLK);
    chk("midrun_busy", in_ready, 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrun_in_ready", in_ready, 1);
    chk("midrun_out_valid", out_valid, 0);
    chk("midrun_quotient", quotient, 0);
    chk("midrun_remainder", remainder, 0);
    chk("midrun_dbz", div_by_zero, 0);
    RST = 1'b1;
    do_op(9, 4, 0, 1'b0);

    for (int i = 0; i < N_RANDOM; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       begin rb = $urandom; ra = W'($urandom_range(0, 1000)); end
        default: rb = $urandom;
      endcase
      do_op(ra, rb, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
